// File: rtl/x_round_sequencer_if.sv
// rtl/x_round_sequencer_if.sv - key load, job handshake and result bundle for the X round sequencer
interface x_round_sequencer_if #(
  parameter int KAW = 4
);
  logic           key_we;
  logic [KAW-1:0] key_addr;
  logic [7:0]     key_din;
  logic           start;
  logic [7:0]     d_in;
  logic           ready;
  logic           busy;
  logic [KAW-1:0] round;
  logic [7:0]     d_out;
  logic           valid;

  modport master (
    output key_we, key_addr, key_din, start, d_in,
    input  ready, busy, round, d_out, valid
  );

  modport slave (
    input  key_we, key_addr, key_din, start, d_in,
    output ready, busy, round, d_out, valid
  );
endinterface

// File: rtl/x_round_sequencer.sv
// rtl/x_round_sequencer.sv - byte-wide XOR-with-key round controller with rotl1 diffusion between rounds
module x_round_sequencer #(
  parameter int ROUNDS = 10,
  parameter int KAW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  x_round_sequencer_if.slave  bus
);
  localparam logic [KAW:0]   ROUNDS_W = (KAW+1)'(ROUNDS);
  localparam logic [KAW-1:0] LAST_RND = KAW'(ROUNDS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         state, state_n;
  logic [7:0]     key_bank [ROUNDS];
  logic [7:0]     st, st_n;
  logic [7:0]     d_out_q, d_out_n;
  logic [7:0]     mix;
  logic [KAW-1:0] round_q, round_n;
  logic           valid_q, valid_n;
  logic           key_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      st      <= 8'h00;
      round_q <= '0;
      d_out_q <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      st      <= st_n;
      round_q <= round_n;
      d_out_q <= d_out_n;
      valid_q <= valid_n;
    end
  end

  // Keys only change while idle, so a job always sees one consistent bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROUNDS; i++) begin
        key_bank[i] <= 8'h00;
      end
    end else if (key_wr) begin
      key_bank[bus.key_addr] <= bus.key_din;
    end
  end

  always_comb begin
    state_n = state;
    st_n    = st;
    round_n = round_q;
    d_out_n = d_out_q;
    valid_n = 1'b0;
    key_wr  = 1'b0;
    mix     = st ^ key_bank[round_q];
    case (state)
      S_IDLE: begin
        key_wr = bus.key_we && ({1'b0, bus.key_addr} < ROUNDS_W);
        if (bus.start) begin
          st_n    = bus.d_in;
          round_n = '0;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        // The final round skips the rotate and publishes the result.
        if (round_q == LAST_RND) begin
          d_out_n = mix;
          valid_n = 1'b1;
          round_n = '0;
          state_n = S_IDLE;
        end else begin
          st_n    = {mix[6:0], mix[7]};
          round_n = round_q + KAW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.busy  = (state == S_RUN);
  assign bus.round = round_q;
  assign bus.d_out = d_out_q;
  assign bus.valid = valid_q;
endmodule
